// File: rtl/crossing_pkg.sv
// Shared definitions for the level-crossing train detection path.
package crossing_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_OCCUPIED = 2'b01,
        ST_FAULT    = 2'b10
    } det_state_t;

endpackage

// File: rtl/sensor_conditioner.sv
// One treadle input: 2-flop synchroniser, stability debounce, rising-edge pulse.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = crossing_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_raw,
    output logic level,
    output logic rise
);

    localparam int DC_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DC_W-1:0] DCNT_TC = DC_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            filt;
    logic            filt_d;
    logic [DC_W-1:0] dcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            dcnt   <= '0;
        end else begin
            sync1  <= sensor_raw;
            sync2  <= sync1;
            filt_d <= filt;
            // filt only follows after DEBOUNCE_CYCLES consecutive disagreeing samples
            if (sync2 == filt) begin
                dcnt <= '0;
            end else if (dcnt == DCNT_TC) begin
                filt <= sync2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DC_W'(1);
            end
        end
    end

    assign level = filt;
    assign rise  = filt & ~filt_d;

endmodule

// File: rtl/train_presence_detector.sv
// Axle counter for the protected section; any counting anomaly latches a fault
// that keeps train_detected asserted until cleared with both treadles idle.
//
//   state       | meaning
//   ------------+---------------------------------------------
//   ST_IDLE     | section empty, count 0, no fault
//   ST_OCCUPIED | count != 0, no fault
//   ST_FAULT    | over/underflow seen, count frozen, events ignored
module train_presence_detector #(
    parameter int DEBOUNCE_CYCLES = crossing_pkg::DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_entry,
    input  logic             sensor_exit,
    input  logic             clear_fault,
    output logic             train_detected,
    output logic [CNT_W-1:0] axle_count,
    output logic             fault
);

    import crossing_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic entry_level, entry_ev;
    logic exit_level, exit_ev;

    det_state_t       state_q, state_nxt;
    logic [CNT_W-1:0] count_nxt;

    sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
        .clk        (clk),
        .reset      (reset),
        .sensor_raw (sensor_entry),
        .level      (entry_level),
        .rise       (entry_ev)
    );

    sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
        .clk        (clk),
        .reset      (reset),
        .sensor_raw (sensor_exit),
        .level      (exit_level),
        .rise       (exit_ev)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            axle_count     <= '0;
            fault          <= 1'b0;
            train_detected <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            axle_count     <= count_nxt;
            fault          <= (state_nxt == ST_FAULT);
            train_detected <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state_q;
        count_nxt = axle_count;
        case (state_q)
            ST_IDLE, ST_OCCUPIED: begin
                // simultaneous entry and exit cancel out
                if (entry_ev && !exit_ev) begin
                    if (axle_count == CNT_MAX) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        count_nxt = axle_count + CNT_W'(1);
                        state_nxt = ST_OCCUPIED;
                    end
                end else if (exit_ev && !entry_ev) begin
                    if (axle_count == '0) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        count_nxt = axle_count - CNT_W'(1);
                        state_nxt = (axle_count == CNT_W'(1)) ? ST_IDLE : ST_OCCUPIED;
                    end
                end
            end
            ST_FAULT: begin
                if (clear_fault && !entry_level && !exit_level) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_train_presence_detector.sv
// Self-checking bench: directed scenarios plus random treadle pulses against a pulse-level model.
module tb_train_presence_detector;

    localparam int DEB   = 4;
    localparam int GAP   = 14;
    localparam int MAX_A = 255;
    localparam int MAX_B = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entry_a = 1'b0, exit_a = 1'b0, clr_a = 1'b0;
    logic       entry_b = 1'b0, exit_b = 1'b0, clr_b = 1'b0;
    logic       det_a, fault_a, det_b, fault_b;
    logic [7:0] count_a;
    logic [2:0] count_b;

    int n_compared = 0;
    int n_mismatched = 0;

    // model state per instance
    int m_cnt_a = 0, m_cnt_b = 0;
    bit m_flt_a = 0, m_flt_b = 0;

    always #5 clk = ~clk;

    train_presence_detector #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .sensor_entry(entry_a), .sensor_exit(exit_a),
        .clear_fault(clr_a), .train_detected(det_a), .axle_count(count_a), .fault(fault_a)
    );

    train_presence_detector #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .sensor_entry(entry_b), .sensor_exit(exit_b),
        .clear_fault(clr_b), .train_detected(det_b), .axle_count(count_b), .fault(fault_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit en, input bit ex, input int maxv,
                              input int c_in, input bit f_in,
                              output int c_out, output bit f_out);
        c_out = c_in;
        f_out = f_in;
        if (!f_in) begin
            if (en && !ex) begin
                if (c_in == maxv) f_out = 1;
                else c_out = c_in + 1;
            end else if (ex && !en) begin
                if (c_in == 0) f_out = 1;
                else c_out = c_in - 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count_a"}, {24'b0, count_a}, m_cnt_a);
        check({tag, ".fault_a"}, {31'b0, fault_a}, {31'b0, m_flt_a});
        check({tag, ".det_a"}, {31'b0, det_a}, {31'b0, (m_flt_a || m_cnt_a != 0)});
        check({tag, ".count_b"}, {29'b0, count_b}, m_cnt_b);
        check({tag, ".fault_b"}, {31'b0, fault_b}, {31'b0, m_flt_b});
        check({tag, ".det_b"}, {31'b0, det_b}, {31'b0, (m_flt_b || m_cnt_b != 0)});
    endtask

    // Raw pulse of len cycles then a quiet gap long enough for both edges to settle.
    task automatic do_op(input bit sel_b, input bit en, input bit ex, input int len, input string tag);
        bit ev_en, ev_ex;
        @(negedge clk);
        if (sel_b) begin entry_b = en; exit_b = ex; end
        else       begin entry_a = en; exit_a = ex; end
        repeat (len) @(negedge clk);
        entry_a = 1'b0; exit_a = 1'b0; entry_b = 1'b0; exit_b = 1'b0;
        repeat (GAP) @(negedge clk);
        ev_en = en && (len >= DEB);
        ev_ex = ex && (len >= DEB);
        if (sel_b) model_step(ev_en, ev_ex, MAX_B, m_cnt_b, m_flt_b, m_cnt_b, m_flt_b);
        else       model_step(ev_en, ev_ex, MAX_A, m_cnt_a, m_flt_a, m_cnt_a, m_flt_a);
        check_all(tag);
    endtask

    task automatic do_clear(input bit sel_b, input string tag);
        @(negedge clk);
        if (sel_b) clr_b = 1'b1; else clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0; clr_b = 1'b0;
        repeat (2) @(negedge clk);
        if (sel_b) begin if (m_flt_b) begin m_flt_b = 0; m_cnt_b = 0; end end
        else       begin if (m_flt_a) begin m_flt_a = 0; m_cnt_a = 0; end end
        check_all(tag);
    endtask

    initial begin
        #23 reset = 1'b0;
        @(negedge clk);
        check_all("reset");

        // latency: raw high before edge k, count moves at edge k+6
        @(negedge clk);
        entry_a = 1'b1;
        repeat (6) @(negedge clk);
        check("lat.count_before", {24'b0, count_a}, 0);
        check("lat.det_before", {31'b0, det_a}, 0);
        @(negedge clk);
        check("lat.count_at", {24'b0, count_a}, 1);
        check("lat.det_at", {31'b0, det_a}, 1);
        repeat (13) @(negedge clk);
        entry_a = 1'b0;
        repeat (GAP) @(negedge clk);
        m_cnt_a = 1;
        check_all("axle1");

        for (int i = 0; i < 3; i++) do_op(0, 1, 0, 20, "train_in");
        for (int i = 0; i < 4; i++) do_op(0, 0, 1, 20, "train_out");

        for (int l = 1; l <= 4; l++) do_op(0, 1, 0, l, "glitch");

        // simultaneous edges at count 2
        do_op(0, 1, 0, 6, "pre_sim");
        do_op(0, 1, 1, 6, "simult");
        do_op(0, 0, 1, 6, "drain1");
        do_op(0, 0, 1, 6, "drain2");

        // underflow, then clear refused while exit treadle still pressed
        @(negedge clk);
        exit_a = 1'b1;
        repeat (12) @(negedge clk);
        model_step(0, 1, MAX_A, m_cnt_a, m_flt_a, m_cnt_a, m_flt_a);
        check_all("underflow");
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        repeat (2) @(negedge clk);
        check_all("clear_blocked");
        exit_a = 1'b0;
        repeat (GAP) @(negedge clk);
        do_op(0, 1, 0, 6, "fault_frozen");
        do_clear(0, "clear_ok");

        // overflow on the 3-bit instance
        for (int i = 0; i < 10; i++) do_op(1, 1, 0, 6, "ovf");
        do_clear(1, "ovf_clear");

        // asynchronous reset mid-train
        for (int i = 0; i < 3; i++) do_op(0, 1, 0, 6, "pre_rst");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        m_cnt_a = 0; m_flt_a = 0; m_cnt_b = 0; m_flt_b = 0;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        do_op(0, 1, 0, 6, "post_rst");

        // random treadle traffic
        for (int i = 0; i < 60; i++) begin
            int r, len;
            bit sel;
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 7);
            sel = $urandom_range(0, 1);
            case (r)
                0, 1, 2, 3: do_op(sel, 1, 0, len, "rnd_entry");
                4, 5, 6:    do_op(sel, 0, 1, len, "rnd_exit");
                7:          do_op(sel, 1, 1, len, "rnd_both");
                default:    do_clear(sel, "rnd_clear");
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
